// File: rtl/uart_baud_frac_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_frac_gen
//   Fractional baud-rate generator for a UART. Produces an oversample tick every
//   act_int (+1 when the fractional phase accumulator carries) clock cycles, so
//   the long-run tick period is act_int + act_frac/2^FRAC_BITS cycles. Every
//   OSR oversample ticks make one bit period; tick_mid marks the bit midpoint
//   and tick_bit marks the end of the bit.
//
//   A new divisor is captured into a shadow register by load and moved into the
//   active register only at a tick boundary (or immediately while disabled),
//   so a running period is never cut short or stretched by reprogramming.
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   enable     in   run the generator; low holds all counters
//   div_int    in   [DIV_BITS]  requested integer divisor (cycles per tick)
//   div_frac   in   [FRAC_BITS] requested fractional divisor (1/2^FRAC_BITS)
//   load       in   capture div_int/div_frac into the shadow register
//   sync_clear in   restart the bit phase (start-bit detect from RX)
//   tick_os    out  single-cycle oversample tick
//   tick_mid   out  single-cycle tick at the bit midpoint
//   tick_bit   out  single-cycle tick at the end of the bit
//   pending    out  shadow divisor waiting to be applied
//   cfg_err    out  sticky: last load carried an illegal zero divisor
// -----------------------------------------------------------------------------
module uart_baud_frac_gen #(
  parameter int DIV_BITS    = 16,
  parameter int FRAC_BITS   = 4,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DIV_BITS-1:0]  div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  input  logic                 load,
  input  logic                 sync_clear,
  output logic                 tick_os,
  output logic                 tick_mid,
  output logic                 tick_bit,
  output logic                 pending,
  output logic                 cfg_err
);

  localparam int OS_BITS = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_BITS-1:0] DEF_DIV = DIV_BITS'(DEFAULT_DIV);
  localparam logic [OS_BITS-1:0]  OS_LAST = OS_BITS'(OSR - 1);
  localparam logic [OS_BITS-1:0]  OS_MID  = OS_BITS'(OSR / 2 - 1);

  logic [DIV_BITS-1:0]  act_int_q,  act_int_d;
  logic [FRAC_BITS-1:0] act_frac_q, act_frac_d;
  logic [DIV_BITS-1:0]  shd_int_q,  shd_int_d;
  logic [FRAC_BITS-1:0] shd_frac_q, shd_frac_d;
  logic [DIV_BITS-1:0]  cnt_q,      cnt_d;
  logic [OS_BITS-1:0]   os_cnt_q,   os_cnt_d;
  logic [FRAC_BITS-1:0] acc_q,      acc_d;
  logic                 extra_q,    extra_d;
  logic                 pending_q,  pending_d;
  logic                 cfg_err_q,  cfg_err_d;

  logic [DIV_BITS:0]    term_s;
  logic [FRAC_BITS:0]   frac_sum_s;
  logic                 tick_os_s;
  logic                 apply_s;

  // Terminal count, tick decode and next-state for all registers.
  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    acc_d      = acc_q;
    extra_d    = extra_q;
    pending_d  = pending_q;
    cfg_err_d  = cfg_err_q;

    // One bit wider than the divisor: act_int >= 1 always, so this never wraps.
    term_s = {1'b0, act_int_q} - {{DIV_BITS{1'b0}}, 1'b1}
           + {{DIV_BITS{1'b0}}, extra_q};
    tick_os_s  = reset_n & enable & ~sync_clear & ({1'b0, cnt_q} == term_s);
    frac_sum_s = {1'b0, acc_q} + {1'b0, act_frac_q};

    if (sync_clear) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      acc_d    = '0;
      extra_d  = 1'b0;
    end else if (enable) begin
      if (tick_os_s) begin
        cnt_d    = '0;
        acc_d    = frac_sum_s[FRAC_BITS-1:0];
        extra_d  = frac_sum_s[FRAC_BITS];
        os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_BITS'(1);
      end else begin
        cnt_d = cnt_q + DIV_BITS'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    // Shadow moves to active on a tick boundary, or at once while idle.
    // os_cnt is deliberately left alone so the bit phase survives.
    apply_s = pending_q & (tick_os_s | ~enable);
    if (apply_s) begin
      act_int_d  = shd_int_q;
      act_frac_d = shd_frac_q;
      acc_d      = '0;
      extra_d    = 1'b0;
      pending_d  = 1'b0;
      if (!enable) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      pending_d = pending_d;
    end

    // A capture in the same cycle as an apply re-arms pending, so the newer
    // value waits for the following tick boundary.
    if (load) begin
      if (div_int == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        shd_int_d  = div_int;
        shd_frac_d = div_frac;
        cfg_err_d  = 1'b0;
        pending_d  = 1'b1;
      end
    end else begin
      cfg_err_d = cfg_err_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_int_q  <= DEF_DIV;
      act_frac_q <= '0;
      shd_int_q  <= DEF_DIV;
      shd_frac_q <= '0;
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      acc_q      <= '0;
      extra_q    <= 1'b0;
      pending_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      acc_q      <= acc_d;
      extra_q    <= extra_d;
      pending_q  <= pending_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick_os  = tick_os_s;
  assign tick_mid = tick_os_s & (os_cnt_q == OS_MID);
  assign tick_bit = tick_os_s & (os_cnt_q == OS_LAST);
  assign pending  = pending_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_frac_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_frac_gen
//   Directed bench for uart_baud_frac_gen built with DEFAULT_DIV=4. Inputs are
//   driven 1 time unit after the rising edge and outputs sampled 1 unit later,
//   well clear of the next edge. Cycle index c counts rising edges after the
//   inputs for that cycle have been applied.
// -----------------------------------------------------------------------------
module tb_uart_baud_frac_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        load;
  logic        sync_clear;
  logic        tick_os, tick_mid, tick_bit, pending, cfg_err;

  int total = 0;
  int bad   = 0;

  uart_baud_frac_gen #(
    .DIV_BITS(16), .FRAC_BITS(4), .OSR(16), .DEFAULT_DIV(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .div_int(div_int),
    .div_frac(div_frac), .load(load), .sync_clear(sync_clear),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
    .pending(pending), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; sync_clear = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; load = 1'b1; sync_clear = 1'b1;
    div_int = 16'd9; div_frac = 4'd3;
    step();
    sync_clear = 1'b0;
    #1;
    total++; if (tick_os !== 1'b0) begin bad++; $display("FAIL reset_tick_os got=%b exp=0", tick_os); end
    total++; if (tick_mid !== 1'b0 || tick_bit !== 1'b0) begin bad++; $display("FAIL reset_tick_mb got=%b%b exp=00", tick_mid, tick_bit); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    step();
    reset_n = 1'b1; load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (tick_os !== (c % 4 == 3)) begin bad++; $display("FAIL reset_period c=%0d got=%b exp=%b", c, tick_os, (c % 4 == 3)); end
      step();
    end
  endtask

  task automatic test_default();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 64; c++) begin
      #1;
      total++; if (tick_os !== (c % 4 == 3)) begin bad++; $display("FAIL default_os c=%0d got=%b exp=%b", c, tick_os, (c % 4 == 3)); end
      total++; if (tick_mid !== (c == 31)) begin bad++; $display("FAIL default_mid c=%0d got=%b exp=%b", c, tick_mid, (c == 31)); end
      total++; if (tick_bit !== (c == 63)) begin bad++; $display("FAIL default_bit c=%0d got=%b exp=%b", c, tick_bit, (c == 63)); end
      step();
    end
  endtask

  task automatic test_frac();
    int exp_t[5] = '{2, 5, 9, 12, 16};
    int got_t[5] = '{-1, -1, -1, -1, -1};
    int n = 0;
    do_reset();
    load = 1'b1; div_int = 16'd3; div_frac = 4'd8;
    step();
    load = 1'b0;
    #1;
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL frac_pending_set got=%b exp=1", pending); end
    step();
    #1;
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL frac_pending_idle_apply got=%b exp=0", pending); end
    enable = 1'b1;
    for (int c = 0; c < 112; c++) begin
      #1;
      if (tick_os === 1'b1) begin
        if (n < 5) got_t[n] = c;
        n++;
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_t[i] !== exp_t[i]) begin bad++; $display("FAIL frac_tick_time i=%0d got=%0d exp=%0d", i, got_t[i], exp_t[i]); end
    end
    total++; if (n !== 32) begin bad++; $display("FAIL frac_tick_count got=%0d exp=32", n); end
  endtask

  task automatic test_pending();
    logic exp_os;
    do_reset();
    enable = 1'b1; div_int = 16'd6; div_frac = 4'd0;
    for (int c = 0; c < 45; c++) begin
      load = (c == 5);
      #1;
      exp_os = (c == 3) || (c == 7) || (c >= 13 && (c - 13) % 6 == 0);
      total++; if (tick_os !== exp_os) begin bad++; $display("FAIL pend_os c=%0d got=%b exp=%b", c, tick_os, exp_os); end
      total++; if (tick_mid !== (c == 43)) begin bad++; $display("FAIL pend_mid c=%0d got=%b exp=%b", c, tick_mid, (c == 43)); end
      total++; if (pending !== (c == 6 || c == 7)) begin bad++; $display("FAIL pend_flag c=%0d got=%b exp=%b", c, pending, (c == 6 || c == 7)); end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_cfg_err();
    do_reset();
    enable = 1'b1; div_frac = 4'd0;
    for (int c = 0; c < 15; c++) begin
      load = (c == 1) || (c == 12);
      div_int = (c == 12) ? 16'd4 : 16'd0;
      #1;
      total++; if (tick_os !== (c % 4 == 3)) begin bad++; $display("FAIL cfg_os c=%0d got=%b exp=%b", c, tick_os, (c % 4 == 3)); end
      total++; if (cfg_err !== (c >= 2 && c <= 12)) begin bad++; $display("FAIL cfg_err c=%0d got=%b exp=%b", c, cfg_err, (c >= 2 && c <= 12)); end
      total++; if (pending !== (c >= 13)) begin bad++; $display("FAIL cfg_pending c=%0d got=%b exp=%b", c, pending, (c >= 13)); end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_sync_clear();
    logic exp_os;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 57; c++) begin
      sync_clear = (c == 23);
      #1;
      exp_os = (c < 23 && c % 4 == 3) || (c >= 27 && (c - 27) % 4 == 0);
      total++; if (tick_os !== exp_os) begin bad++; $display("FAIL sclr_os c=%0d got=%b exp=%b", c, tick_os, exp_os); end
      total++; if (tick_mid !== (c == 55)) begin bad++; $display("FAIL sclr_mid c=%0d got=%b exp=%b", c, tick_mid, (c == 55)); end
      step();
    end
    sync_clear = 1'b0;
  endtask

  task automatic test_enable_hold();
    do_reset();
    for (int c = 0; c < 22; c++) begin
      enable = !(c >= 6 && c <= 15);
      #1;
      total++; if (tick_os !== (c == 3 || c == 17 || c == 21)) begin bad++; $display("FAIL hold_os c=%0d got=%b exp=%b", c, tick_os, (c == 3 || c == 17 || c == 21)); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_os;
    do_reset();
    enable = 1'b1; div_frac = 4'd0;
    for (int c = 0; c < 17; c++) begin
      load = (c == 3) || (c == 5) || (c == 9);
      div_int = (c == 5) ? 16'd2 : 16'd1;
      #1;
      exp_os = (c == 3) || (c == 7) || (c == 9) || (c >= 11);
      total++; if (tick_os !== exp_os) begin bad++; $display("FAIL b2b_os c=%0d got=%b exp=%b", c, tick_os, exp_os); end
      total++; if (pending !== ((c >= 4 && c <= 7) || c == 10 || c == 11)) begin
        bad++; $display("FAIL b2b_pending c=%0d got=%b exp=%b", c, pending, ((c >= 4 && c <= 7) || c == 10 || c == 11));
      end
      step();
    end
    // Reset while a capture is pending drops it and restores the default.
    load = 1'b1; div_int = 16'd7;
    step();
    load = 1'b0;
    #1;
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL b2b_pre_reset_pending got=%b exp=1", pending); end
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      total++; if (tick_os !== (c % 4 == 3)) begin bad++; $display("FAIL b2b_post_reset c=%0d got=%b exp=%b", c, tick_os, (c % 4 == 3)); end
      total++; if (pending !== 1'b0) begin bad++; $display("FAIL b2b_post_reset_pending c=%0d got=%b exp=0", c, pending); end
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; sync_clear = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;
    #1;
    test_reset();
    test_default();
    test_frac();
    test_pending();
    test_cfg_err();
    test_sync_clear();
    test_enable_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
